// File: rtl/regfile_wb_bypass.sv
// regfile_wb_bypass
//   Decode-stage register file with NRD combinational read ports, a registered
//   write-back stage (optionally forwarded to reads), a load scoreboard that
//   flags load-use hazards, and a 16-bit immediate extender.
//
// Ports
//   clock, reset     rising-edge clock; synchronous active-high reset
//   i_rd_addr        NRD packed read addresses, port k at [k*ADDR_W +: ADDR_W]
//   o_rd_data        NRD packed read data,      port k at [k*DATA_W +: DATA_W]
//   i_imm_in         raw 16-bit immediate
//   i_imm_zext       1: zero-extend, 0: sign-extend
//   o_imm_out        extended immediate (combinational)
//   i_wb_valid       write-back request this cycle
//   i_wb_jal         link write: destination LINK_REG, data i_wb_link
//   i_wb_mem_to_reg  data select: 1 i_mem_data, 0 i_alu_result
//   i_wb_addr        destination when i_wb_jal=0
//   i_alu_result     execute result
//   i_mem_data       load / IO read data
//   i_wb_link        PC+4 from fetch
//   i_ld_issue       a load targeting i_ld_addr issues this cycle
//   i_ld_addr        load destination register
//   o_stall          load-use hazard on any read port
//
// Handshake: i_wb_valid and i_ld_issue are single-cycle strobes with no ready;
// the block accepts one write-back and one load issue on every rising edge
// where the strobe is high, and its payload is sampled only on that edge.
module regfile_wb_bypass #(
  parameter int DATA_W   = 32,
  parameter int NREGS    = 32,
  parameter int NRD      = 2,
  parameter int BYPASS   = 1,
  parameter int LINK_REG = 31,
  localparam int ADDR_W  = $clog2(NREGS)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NRD*ADDR_W-1:0]   i_rd_addr,
  output logic [NRD*DATA_W-1:0]   o_rd_data,
  input  logic [15:0]             i_imm_in,
  input  logic                    i_imm_zext,
  output logic [DATA_W-1:0]       o_imm_out,
  input  logic                    i_wb_valid,
  input  logic                    i_wb_jal,
  input  logic                    i_wb_mem_to_reg,
  input  logic [ADDR_W-1:0]       i_wb_addr,
  input  logic [DATA_W-1:0]       i_alu_result,
  input  logic [DATA_W-1:0]       i_mem_data,
  input  logic [DATA_W-1:0]       i_wb_link,
  input  logic                    i_ld_issue,
  input  logic [ADDR_W-1:0]       i_ld_addr,
  output logic                    o_stall
);

  localparam logic [ADDR_W-1:0] LINK_A = ADDR_W'(LINK_REG);

  logic [DATA_W-1:0] r_regs [NREGS];
  logic [NREGS-1:0]  r_busy;
  logic              r_stg_v;
  logic [ADDR_W-1:0] r_stg_a;
  logic [DATA_W-1:0] r_stg_d;

  logic [DATA_W-1:0] w_wb_d;
  logic [ADDR_W-1:0] w_wb_a;
  logic              w_commit;
  logic [NREGS-1:0]  w_busy_nxt;
  logic [NRD-1:0]    w_port_stall;

  assign w_wb_d   = i_wb_jal ? i_wb_link : (i_wb_mem_to_reg ? i_mem_data : i_alu_result);
  assign w_wb_a   = i_wb_jal ? LINK_A : i_wb_addr;
  // Register 0 is hard-wired zero, so a staged write to it is simply dropped.
  assign w_commit = r_stg_v && (r_stg_a != '0);

  // Clear on commit first, then set on a new load, so a load issued on the
  // same edge that the previous value commits keeps the register busy.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_commit) w_busy_nxt[r_stg_a] = 1'b0;
    if (i_ld_issue && (i_ld_addr != '0)) w_busy_nxt[i_ld_addr] = 1'b1;
  end

  // Write-back stage: captured on edge N, committed to the array on edge N+1.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_stg_v <= 1'b0;
      r_stg_a <= '0;
      r_stg_d <= '0;
    end else begin
      r_stg_v <= i_wb_valid;
      if (i_wb_valid) r_stg_a <= w_wb_a;
      r_stg_d <= w_wb_d;
    end
  end

  // Reset discards any pending stage entry instead of committing it.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else if (w_commit) begin
      r_regs[r_stg_a] <= r_stg_d;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) r_busy <= '0;
    else       r_busy <= w_busy_nxt;
  end

  // Per-port read: zero register, then forwarded stage data, then the array.
  // A forwarded hit also satisfies a pending load, so it masks the stall.
  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [ADDR_W-1:0] w_a;
    logic              w_hit;
    assign w_a   = i_rd_addr[k*ADDR_W +: ADDR_W];
    assign w_hit = (BYPASS != 0) && r_stg_v && (r_stg_a == w_a);
    assign o_rd_data[k*DATA_W +: DATA_W] = (w_a == '0) ? '0 :
                                           (w_hit ? r_stg_d : r_regs[w_a]);
    assign w_port_stall[k] = (w_a != '0) && r_busy[w_a] && !w_hit;
  end

  assign o_stall = |w_port_stall;

  assign o_imm_out = i_imm_zext ? {{(DATA_W-16){1'b0}}, i_imm_in}
                                : {{(DATA_W-16){i_imm_in[15]}}, i_imm_in};

endmodule
